// File: rtl/module_arbitro_de_bus.sv
// rtl/module_arbitro_de_bus.sv - two-master round-robin bus arbiter/sequencer
// One single-word transaction per grant; reads wait RD_LAT cycles before capture.
module module_arbitro_de_bus #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    output logic          ack0_o,
    output logic [DW-1:0] rdata0_o,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack1_o,
    output logic [DW-1:0] rdata1_o,
    output logic [1:0]    gnt_o,
    output logic          busy_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    input  logic [DW-1:0] di_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [2:0] LP_CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic          r_sel;
    logic          r_is_wr;
    logic [1:0]    r_gnt;
    logic          r_busy;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic w_any;
    logic w_pick1;
    logic w_done;
    logic w_cap;

    // On a tie the master that did not go last wins.
    assign w_any   = req0_i | req1_i;
    assign w_pick1 = req1_i & (~req0_i | ~r_last);

    assign w_done = ((r_state == S_ACCESS) && (r_is_wr || (RD_LAT == 0)))
                  || ((r_state == S_WAIT) && (r_cnt == 3'd0));
    assign w_cap  = w_done && !r_is_wr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_is_wr  <= 1'b0;
            r_gnt    <= 2'b00;
            r_busy   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_we   <= 1'b0;

            if (w_cap) begin
                if (r_sel) r_rdata1 <= di_i;
                else       r_rdata0 <= di_i;
            end

            if (w_done) begin
                r_ack0  <= ~r_sel;
                r_ack1  <= r_sel;
                r_state <= S_ACK;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_sel   <= w_pick1;
                            r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                            r_addr  <= w_pick1 ? addr1_i : addr0_i;
                            r_wdata <= w_pick1 ? wdata1_i : wdata0_i;
                            r_is_wr <= w_pick1 ? we1_i : we0_i;
                            r_we    <= w_pick1 ? we1_i : we0_i;
                            r_busy  <= 1'b1;
                            r_state <= S_ACCESS;
                        end
                    end
                    S_ACCESS: begin
                        r_cnt   <= LP_CNT_INIT;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                    default: begin
                        r_last  <= r_sel;
                        r_gnt   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ack0_o   = r_ack0;
    assign ack1_o   = r_ack1;
    assign rdata0_o = r_rdata0;
    assign rdata1_o = r_rdata1;
    assign gnt_o    = r_gnt;
    assign busy_o   = r_busy;
    assign we_o     = r_we;
    assign addr_o   = r_addr;
    assign wdata_o  = r_wdata;

endmodule

// File: tb/tb_module_arbitro_de_bus.sv
// tb/tb_module_arbitro_de_bus.sv - self-checking bench for module_arbitro_de_bus
// Reference model plans each round as a timeline of grants/acks from the arbitration rules.
module tb_module_arbitro_de_bus;

    localparam int RD_LAT = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
    logic        ack0_o, ack1_o, busy_o, we_o;
    logic [31:0] rdata0_o, rdata1_o, addr_o, wdata_o, di_i;
    logic [1:0]  gnt_o;

    always #5 clk_i = ~clk_i;

    module_arbitro_de_bus #(.RD_LAT(RD_LAT), .AW(32), .DW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
        .ack0_o(ack0_o), .rdata0_o(rdata0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .ack1_o(ack1_o), .rdata1_o(rdata1_o),
        .gnt_o(gnt_o), .busy_o(busy_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .di_i(di_i)
    );

    // Slave side: word RAM; addresses with bit 15 set are unmapped and read as 0.
    logic [31:0] bus_mem [0:255] = '{default: 32'h0};
    always @(posedge clk_i) if (we_o && !addr_o[15]) bus_mem[addr_o[9:2]] <= wdata_o;
    always_comb di_i = addr_o[15] ? 32'h0 : bus_mem[addr_o[9:2]];

    logic [31:0] ref_mem [0:255] = '{default: 32'h0};
    bit          m_last = 1'b1;
    logic [31:0] hold [2] = '{32'h0, 32'h0};
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return a[15] ? 32'h0 : ref_mem[a[9:2]];
    endfunction

    task automatic release_req(input int j, input bit scramble);
        if (j == 0) begin
            req0_i = 1'b0;
            if (scramble) begin addr0_i = ~addr0_i; wdata0_i = $urandom; we0_i = ~we0_i; end
        end else begin
            req1_i = 1'b0;
            if (scramble) begin addr1_i = ~addr1_i; wdata1_i = $urandom; we1_i = ~we1_i; end
        end
    endtask

    task automatic run_round(input bit rq0, input bit rq1, input bit w0, input bit w1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1, input bit drop_early);
        bit          pend [2];
        bit          wv [2];
        logic [31:0] av [2], dv [2], rdv [2];
        int          sel_c [2], ack_c [2];
        int          t = 0;
        int          m;
        logic [1:0]  eg;
        logic        ewe;
        pend = '{rq0, rq1}; wv = '{w0, w1}; av = '{a0, a1}; dv = '{d0, d1};
        rdv = '{32'h0, 32'h0}; sel_c = '{-10, -10}; ack_c = '{-10, -10};
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) m = m_last ? 0 : 1;
            else                    m = pend[0] ? 0 : 1;
            sel_c[m] = t;
            ack_c[m] = t + 2 + (wv[m] ? 0 : RD_LAT);
            if (wv[m]) begin
                if (!av[m][15]) ref_mem[av[m][9:2]] = dv[m];
            end else begin
                rdv[m] = model_read(av[m]);
            end
            m_last  = (m == 1);
            pend[m] = 1'b0;
            t       = ack_c[m] + 1;
        end
        req0_i = rq0; we0_i = w0; addr0_i = a0; wdata0_i = d0;
        req1_i = rq1; we1_i = w1; addr1_i = a1; wdata1_i = d1;
        for (int k = 1; k <= t; k++) begin
            tick();
            eg = 2'b00; ewe = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (k > sel_c[j] && k <= ack_c[j]) eg[j] = 1'b1;
                if (k == sel_c[j] + 1) begin
                    ewe = wv[j];
                    chk("addr_access", addr_o, av[j]);
                    if (wv[j]) chk("wdata_access", wdata_o, dv[j]);
                end
                if (k == ack_c[j] && !wv[j]) hold[j] = rdv[j];
            end
            chk("ack0", ack0_o, (k == ack_c[0]));
            chk("ack1", ack1_o, (k == ack_c[1]));
            chk("gnt", gnt_o, eg);
            chk("busy", busy_o, |eg);
            chk("we", we_o, ewe);
            chk("rdata0", rdata0_o, hold[0]);
            chk("rdata1", rdata1_o, hold[1]);
            for (int j = 0; j < 2; j++) begin
                if (k == ack_c[j]) release_req(j, 1'b0);
                else if (drop_early && k == sel_c[j] + 1) release_req(j, 1'b1);
            end
        end
    endtask

    initial begin
        logic [31:0] ra0, ra1;
        int          n, cyc, prev, got, expm;
        rst_i = 1'b1;
        req0_i = 0; we0_i = 0; addr0_i = 0; wdata0_i = 0;
        req1_i = 0; we1_i = 0; addr1_i = 0; wdata1_i = 0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_ack0", ack0_o, 1'b0);
        chk("rst_ack1", ack1_o, 1'b0);
        chk("rst_rdata0", rdata0_o, 32'h0);
        chk("rst_rdata1", rdata1_o, 32'h0);

        run_round(1, 1, 1, 1, 32'h0000_0100, 32'h0000_0104, 32'h1, 32'h2, 0);
        run_round(1, 0, 1, 0, 32'h0000_2008, 32'h0, 32'h0000_00A5, 32'h0, 0);
        run_round(1, 0, 1, 0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
        run_round(0, 1, 0, 0, 32'h0, 32'h0000_1004, 32'h0, 32'h0, 0);
        run_round(0, 1, 0, 0, 32'h0, 32'h0000_9004, 32'h0, 32'h0, 0);

        // Both masters hold requests through six transactions.
        req0_i = 1; we0_i = 1; addr0_i = 32'h40; wdata0_i = 32'h1111_0000;
        req1_i = 1; we1_i = 1; addr1_i = 32'h44; wdata1_i = 32'h2222_0000;
        n = 0; cyc = 0; prev = -1;
        while (n < 6 && cyc < 100) begin
            tick();
            cyc++;
            if (ack0_o || ack1_o) begin
                got  = ack1_o ? 1 : 0;
                expm = m_last ? 0 : 1;
                chk("alt_order", got, expm);
                chk("alt_no_repeat", (got != prev), 1'b1);
                chk("alt_single_ack", (ack0_o & ack1_o), 1'b0);
                m_last = (expm == 1);
                if (expm == 0) ref_mem[8'h10] = 32'h1111_0000;
                else           ref_mem[8'h11] = 32'h2222_0000;
                prev = got;
                n++;
                if (n == 6) begin req0_i = 0; req1_i = 0; end
            end
        end
        chk("alt_count", n, 6);
        tick();
        chk("alt_idle_busy", busy_o, 1'b0);

        run_round(1, 0, 0, 0, 32'h0000_1004, 32'h0, 32'h0, 32'h0, 1);

        for (int r = 0; r < 40; r++) begin
            bit q0, q1;
            q0 = 1'($urandom_range(0, 1));
            q1 = 1'($urandom_range(0, 1));
            if (!q0 && !q1) q0 = 1'b1;
            ra0 = {16'h0, ($urandom_range(0, 7) == 0), 10'h0, 3'($urandom_range(0, 3)), 2'b00};
            ra1 = {16'h0, ($urandom_range(0, 7) == 0), 10'h0, 3'($urandom_range(0, 3)), 2'b00};
            run_round(q0, q1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ra0, ra1, $urandom, $urandom, ($urandom_range(0, 3) == 0));
        end

        // Reset while a read sits in WAIT.
        req0_i = 1; we0_i = 0; addr0_i = 32'h0000_1004;
        tick();
        tick();
        rst_i = 1'b1; req0_i = 1'b0;
        tick();
        rst_i = 1'b0;
        chk("rstw_ack0", ack0_o, 1'b0);
        chk("rstw_gnt", gnt_o, 2'b00);
        chk("rstw_busy", busy_o, 1'b0);
        chk("rstw_addr", addr_o, 32'h0);
        chk("rstw_rdata0", rdata0_o, 32'h0);
        m_last = 1'b1;
        hold   = '{32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw_no_ack", ack0_o, 1'b0);
            chk("rstw_idle", busy_o, 1'b0);
        end

        run_round(1, 1, 0, 1, 32'h0000_1004, 32'h0000_0008, 32'h0, 32'h5A5A_0001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
